// File: rtl/bf_controller_if.sv
// Adjacency-row load bus between the external row source and bf_controller.
//
// Signals:
//   load_valid   : source has a row beat on the bus
//   load_ready   : controller is in its load phase and accepts beats
//   row_addr     : index of the row currently being written, $clog2(N) bits
//   write_enable : datapath row write strobe (a beat is accepted this cycle)
//
// Modports:
//   master : row source / datapath side (drives load_valid)
//   slave  : controller side (drives load_ready, row_addr, write_enable)
interface bf_controller_if #(
  parameter int N = 32
) ();
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;

  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] row_addr;
  logic              write_enable;

  modport master (
    output load_valid,
    input  load_ready,
    input  row_addr,
    input  write_enable
  );

  modport slave (
    input  load_valid,
    output load_ready,
    output row_addr,
    output write_enable
  );
endinterface

// File: rtl/bf_controller.sv
// Bellman-Ford run controller.
//
// Sequences one run of the relaxation datapath: loads N adjacency rows over
// the load bus, then enables relaxation iterations until the datapath
// reports no change (converged), MAX_ITER iterations have completed, or the
// datapath raises finish.
//
// Ports:
//   clk                        : sole clock, rising edge
//   rst_global                 : synchronous active-high reset
//   start                      : begin a new run (accepted in IDLE or DONE)
//   load_bus                   : row load bus (slave side)
//   read_enable                : datapath relaxation enable
//   iteration_done             : one-cycle pulse after each iteration rollover
//   rollover_phase_counter     : datapath end-of-iteration
//   pre_rollover_phase_counter : datapath one cycle before rollover
//   finish                     : datapath termination request
//   no_change                  : no distance updated (valid with rollover)
//   busy                       : loading or running
//   done                       : run complete, held until next start
//   converged                  : run ended because nothing changed
//   iter_count                 : completed iterations of the current run
//
// All outputs are registered except load_bus.write_enable, which follows
// load_valid in the same cycle so no beat is lost.
module bf_controller #(
  parameter int N        = 32,
  parameter int ITER_W   = 11,
  parameter int MAX_ITER = 31
) (
  input  logic              clk,
  input  logic              rst_global,
  input  logic              start,
  bf_controller_if.slave    load_bus,
  output logic              read_enable,
  output logic              iteration_done,
  input  logic              rollover_phase_counter,
  input  logic              pre_rollover_phase_counter,
  input  logic              finish,
  input  logic              no_change,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count
);

  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(N - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);
  localparam logic [ITER_W-1:0] ITER_SAT  = {ITER_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] row_addr_reg, row_addr_next;
  logic [ITER_W-1:0] iter_count_reg, iter_count_next;
  logic              converged_reg, converged_next;
  logic              iteration_done_reg, iteration_done_next;
  logic              load_ready_reg, load_ready_next;
  logic              read_enable_reg, read_enable_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              last_read_cut;

  // A beat is accepted whenever the source offers one during LOAD.
  assign load_bus.write_enable = (state_reg == LOAD) && load_bus.load_valid;

  // The relaxation enable is registered, so it is decided one cycle ahead
  // using pre_rollover: it drops for the rollover cycle of the final
  // iteration (or of an iteration being cut short by finish).
  assign last_read_cut = (state_reg == RUN) && pre_rollover_phase_counter &&
                         ((iter_count_reg == LAST_ITER) || finish);

  always_comb begin
    state_next          = state_reg;
    row_addr_next       = row_addr_reg;
    iter_count_next     = iter_count_reg;
    converged_next      = converged_reg;
    iteration_done_next = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next      = LOAD;
          row_addr_next   = '0;
          iter_count_next = '0;
          converged_next  = 1'b0;
        end
      end

      LOAD: begin
        if (load_bus.load_valid) begin
          if (row_addr_reg == LAST_ROW) begin
            row_addr_next = '0;
            state_next    = RUN;
          end else begin
            row_addr_next = row_addr_reg + 1'b1;
          end
        end
      end

      RUN: begin
        if (rollover_phase_counter) begin
          iteration_done_next = 1'b1;
          if (iter_count_reg != ITER_SAT) begin
            iter_count_next = iter_count_reg + 1'b1;
          end
          // Convergence takes priority: a converged last iteration still
          // reports converged.
          if (no_change) begin
            converged_next = 1'b1;
            state_next     = DONE;
          end else if (iter_count_reg == LAST_ITER) begin
            state_next = DONE;
          end
        end
        if (finish) begin
          state_next = DONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    load_ready_next  = (state_next == LOAD);
    busy_next        = (state_next == LOAD) || (state_next == RUN);
    done_next        = (state_next == DONE);
    read_enable_next = (state_next == RUN) && !last_read_cut;
  end

  always_ff @(posedge clk) begin
    if (rst_global) begin
      state_reg          <= IDLE;
      row_addr_reg       <= '0;
      iter_count_reg     <= '0;
      converged_reg      <= 1'b0;
      iteration_done_reg <= 1'b0;
      load_ready_reg     <= 1'b0;
      read_enable_reg    <= 1'b0;
      busy_reg           <= 1'b0;
      done_reg           <= 1'b0;
    end else begin
      state_reg          <= state_next;
      row_addr_reg       <= row_addr_next;
      iter_count_reg     <= iter_count_next;
      converged_reg      <= converged_next;
      iteration_done_reg <= iteration_done_next;
      load_ready_reg     <= load_ready_next;
      read_enable_reg    <= read_enable_next;
      busy_reg           <= busy_next;
      done_reg           <= done_next;
    end
  end

  assign load_bus.load_ready = load_ready_reg;
  assign load_bus.row_addr   = row_addr_reg;
  assign read_enable         = read_enable_reg;
  assign iteration_done      = iteration_done_reg;
  assign busy                = busy_reg;
  assign done                = done_reg;
  assign converged           = converged_reg;
  assign iter_count          = iter_count_reg;

endmodule
